// File: rtl/ip_codma_read_machine.sv
// Read-side responder for the CODMA main machine: runs one burst read of 2, 4 or 8
// 32-bit beats on the system bus and gathers them into a 256-bit data register.
module ip_codma_read_machine #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 9
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         need_read_i,
    input  logic [31:0]  reg_addr_i,
    input  logic [7:0]   reg_size_i,
    output logic         need_read_o,
    output logic [255:0] data_reg_o,
    output logic [1:0]   rd_state_o,
    output logic         rd_state_error_o,
    output logic         bus_req_o,
    output logic [31:0]  bus_addr_o,
    output logic [7:0]   bus_size_o,
    input  logic         bus_gnt_i,
    input  logic         bus_rvalid_i,
    input  logic [31:0]  bus_rdata_i,
    input  logic         bus_error_i
);

    // Handshake: need_read_i is a level sampled only in IDLE; need_read_o stays high
    // for the whole read and its falling edge (without an error pulse) marks
    // data_reg_o valid. On the bus, bus_req_o holds until bus_gnt_i is sampled in
    // REQUEST, after which every cycle with bus_rvalid_i high delivers one beat.

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        GRANTED = 2'd2,
        ERROR   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [2:0]       beat_cnt;
    logic [2:0]       last_beat;
    logic [CNT_W-1:0] tmo_cnt;

    logic             req_legal;
    logic [2:0]       req_last;
    logic             accept;
    logic             timeout_hit;

    always_comb begin
        req_legal = 1'b1;
        req_last  = 3'd0;
        case (reg_size_i)
            8'd3:    req_last = 3'd1;
            8'd8:    req_last = 3'd3;
            8'd9:    req_last = 3'd7;
            default: req_legal = 1'b0;
        endcase
    end

    assign accept      = need_read_i && !need_read_o;
    assign timeout_hit = (tmo_cnt == TMO_LAST);
    assign rd_state_o  = state;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state            <= IDLE;
            need_read_o      <= 1'b0;
            data_reg_o       <= '0;
            rd_state_error_o <= 1'b0;
            bus_req_o        <= 1'b0;
            bus_addr_o       <= '0;
            bus_size_o       <= '0;
            beat_cnt         <= '0;
            last_beat        <= '0;
            tmo_cnt          <= '0;
        end else begin
            rd_state_error_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        bus_addr_o <= reg_addr_i;
                        bus_size_o <= reg_size_i;
                        last_beat  <= req_last;
                        data_reg_o <= '0;
                        beat_cnt   <= '0;
                        tmo_cnt    <= '0;
                        if (!req_legal || (reg_addr_i[1:0] != 2'b00)) begin
                            state            <= ERROR;
                            rd_state_error_o <= 1'b1;
                        end else begin
                            state       <= REQUEST;
                            need_read_o <= 1'b1;
                            bus_req_o   <= 1'b1;
                        end
                    end
                end

                REQUEST: begin
                    // A bus error outranks a grant seen in the same cycle.
                    if (bus_error_i || (!bus_gnt_i && timeout_hit)) begin
                        state            <= ERROR;
                        rd_state_error_o <= 1'b1;
                        need_read_o      <= 1'b0;
                        bus_req_o        <= 1'b0;
                    end else if (bus_gnt_i) begin
                        state     <= GRANTED;
                        bus_req_o <= 1'b0;
                        tmo_cnt   <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                GRANTED: begin
                    // An erroring beat is dropped, leaving earlier words untouched.
                    if (bus_error_i || (!bus_rvalid_i && timeout_hit)) begin
                        state            <= ERROR;
                        rd_state_error_o <= 1'b1;
                        need_read_o      <= 1'b0;
                        bus_req_o        <= 1'b0;
                    end else if (bus_rvalid_i) begin
                        data_reg_o[{beat_cnt, 5'b00000} +: 32] <= bus_rdata_i;
                        beat_cnt <= beat_cnt + 1'b1;
                        tmo_cnt  <= '0;
                        if (beat_cnt == last_beat) begin
                            state       <= IDLE;
                            need_read_o <= 1'b0;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                ERROR: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ip_codma_read_machine.sv
// Directed bench for ip_codma_read_machine: bursts of each legal size, illegal
// requests, bus error, grant timeout and reset in the middle of a burst.
module tb_ip_codma_read_machine;

    logic         clk = 1'b0;
    logic         reset_i = 1'b1;
    logic         need_read_i = 1'b0;
    logic [31:0]  reg_addr_i = '0;
    logic [7:0]   reg_size_i = '0;
    logic         need_read_o;
    logic [255:0] data_reg_o;
    logic [1:0]   rd_state_o;
    logic         rd_state_error_o;
    logic         bus_req_o;
    logic [31:0]  bus_addr_o;
    logic [7:0]   bus_size_o;
    logic         bus_gnt_i = 1'b0;
    logic         bus_rvalid_i = 1'b0;
    logic [31:0]  bus_rdata_i = '0;
    logic         bus_error_i = 1'b0;

    int n_pass  = 0;
    int n_total = 0;
    int err_cnt = 0;
    int req_cnt = 0;
    int err_base;
    int req_base;
    logic [31:0] exp_q[$];

    ip_codma_read_machine #(
        .TIMEOUT_CYCLES(8),
        .CNT_W(4)
    ) dut (
        .clk_i(clk),
        .reset_i(reset_i),
        .need_read_i(need_read_i),
        .reg_addr_i(reg_addr_i),
        .reg_size_i(reg_size_i),
        .need_read_o(need_read_o),
        .data_reg_o(data_reg_o),
        .rd_state_o(rd_state_o),
        .rd_state_error_o(rd_state_error_o),
        .bus_req_o(bus_req_o),
        .bus_addr_o(bus_addr_o),
        .bus_size_o(bus_size_o),
        .bus_gnt_i(bus_gnt_i),
        .bus_rvalid_i(bus_rvalid_i),
        .bus_rdata_i(bus_rdata_i),
        .bus_error_i(bus_error_i)
    );

    always #5 clk = ~clk;

    // Count error pulses and bus request cycles away from the active edge.
    always @(negedge clk) begin
        if (rd_state_error_o) err_cnt++;
        if (bus_req_o) req_cnt++;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [255:0] pack_exp();
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < exp_q.size(); i++) v[i*32 +: 32] = exp_q[i];
        return v;
    endfunction

    task automatic request(input logic [31:0] addr, input logic [7:0] size);
        need_read_i = 1'b1;
        reg_addr_i  = addr;
        reg_size_i  = size;
        tick();
        need_read_i = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d);
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = d;
        exp_q.push_back(d);
        tick();
        bus_rvalid_i = 1'b0;
    endtask

    initial begin
        // Reset
        reset_i = 1'b1;
        tick(2);
        chk("rst_state", rd_state_o, 2'd0);
        chk("rst_need", need_read_o, 1'b0);
        chk("rst_data", data_reg_o, '0);
        chk("rst_busreq", bus_req_o, 1'b0);
        chk("rst_err", rd_state_error_o, 1'b0);
        reset_i = 1'b0;
        tick();

        // 1: size 9, grant after 3 cycles, beats with one-cycle gaps
        err_base = err_cnt;
        request(32'h0000_1000, 8'd9);
        chk("t1_state_req", rd_state_o, 2'd1);
        chk("t1_busreq", bus_req_o, 1'b1);
        chk("t1_need", need_read_o, 1'b1);
        reg_addr_i = 32'hDEAD_BEE0;
        reg_size_i = 8'd3;
        tick(2);
        chk("t1_addr_held", bus_addr_o, 32'h0000_1000);
        chk("t1_size", bus_size_o, 8'd9);
        bus_gnt_i = 1'b1;
        tick();
        bus_gnt_i = 1'b0;
        chk("t1_state_gnt", rd_state_o, 2'd2);
        chk("t1_busreq_low", bus_req_o, 1'b0);
        for (int i = 0; i < 8; i++) begin
            beat(32'hA0 + i);
            chk("t1_need_beat", need_read_o, (i < 7) ? 1'b1 : 1'b0);
            tick();
        end
        chk("t1_data", data_reg_o, pack_exp());
        chk("t1_state_idle", rd_state_o, 2'd0);
        chk("t1_no_err", err_cnt - err_base, 0);
        exp_q.delete();

        // 2: size 3, immediate grant; rvalid during REQUEST must be ignored
        bus_gnt_i = 1'b1;
        request(32'h0000_0020, 8'd3);
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'h99;
        tick();
        bus_gnt_i = 1'b0;
        bus_rvalid_i = 1'b0;
        chk("t2_state_gnt", rd_state_o, 2'd2);
        beat(32'h11);
        chk("t2_need_mid", need_read_o, 1'b1);
        beat(32'h22);
        chk("t2_need_done", need_read_o, 1'b0);
        chk("t2_state_idle", rd_state_o, 2'd0);
        chk("t2_data", data_reg_o, pack_exp());
        exp_q.delete();

        // 3: illegal size, then misaligned address
        err_base = err_cnt;
        req_base = req_cnt;
        request(32'h0000_0040, 8'd5);
        chk("t3a_state", rd_state_o, 2'd3);
        chk("t3a_err", rd_state_error_o, 1'b1);
        chk("t3a_need", need_read_o, 1'b0);
        tick();
        chk("t3a_idle", rd_state_o, 2'd0);
        chk("t3a_err_low", rd_state_error_o, 1'b0);
        chk("t3a_data_clr", data_reg_o, '0);
        request(32'h0000_1002, 8'd3);
        chk("t3b_state", rd_state_o, 2'd3);
        chk("t3b_err", rd_state_error_o, 1'b1);
        tick();
        chk("t3b_idle", rd_state_o, 2'd0);
        chk("t3_no_busreq", req_cnt - req_base, 0);
        chk("t3_err_pulses", err_cnt - err_base, 2);

        // 4: bus error together with the third beat of a size-8 read
        bus_gnt_i = 1'b1;
        request(32'h0000_0300, 8'd8);
        tick();
        bus_gnt_i = 1'b0;
        beat(32'hB0);
        beat(32'hB1);
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'hB2;
        bus_error_i  = 1'b1;
        tick();
        bus_rvalid_i = 1'b0;
        bus_error_i  = 1'b0;
        chk("t4_state_err", rd_state_o, 2'd3);
        chk("t4_err", rd_state_error_o, 1'b1);
        chk("t4_need", need_read_o, 1'b0);
        chk("t4_partial", data_reg_o, pack_exp());
        exp_q.delete();
        tick();
        chk("t4_idle", rd_state_o, 2'd0);
        bus_gnt_i = 1'b1;
        request(32'h0000_0400, 8'd3);
        chk("t4_reaccept", rd_state_o, 2'd1);
        tick();
        bus_gnt_i = 1'b0;
        beat(32'hC0);
        beat(32'hC1);
        chk("t4_done_need", need_read_o, 1'b0);
        chk("t4_done_data", data_reg_o, pack_exp());
        exp_q.delete();

        // 5: grant never arrives, timeout of 8 cycles
        request(32'h0000_0500, 8'd3);
        for (int i = 0; i < 8; i++) begin
            chk("t5_busreq", bus_req_o, 1'b1);
            tick();
        end
        chk("t5_state_err", rd_state_o, 2'd3);
        chk("t5_err", rd_state_error_o, 1'b1);
        chk("t5_busreq_low", bus_req_o, 1'b0);
        tick();
        chk("t5_idle", rd_state_o, 2'd0);
        chk("t5_err_low", rd_state_error_o, 1'b0);

        // 6: reset after 2 of 4 beats
        bus_gnt_i = 1'b1;
        request(32'h0000_0600, 8'd8);
        tick();
        bus_gnt_i = 1'b0;
        beat(32'hD0);
        beat(32'hD1);
        chk("t6_state_gnt", rd_state_o, 2'd2);
        chk("t6_partial", data_reg_o, pack_exp());
        exp_q.delete();
        err_base = err_cnt;
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        chk("t6_idle", rd_state_o, 2'd0);
        chk("t6_data_clr", data_reg_o, '0);
        chk("t6_need", need_read_o, 1'b0);
        chk("t6_busreq", bus_req_o, 1'b0);
        tick();
        chk("t6_no_err", err_cnt - err_base, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
